// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmitter between NREQ byte requesters.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx_scheduler #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        baudselect,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              txd,
  output logic              busy,
  output logic [IDX_W-1:0]  owner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  owner_q;
  logic [NREQ-1:0]   gnt_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_idx_q;
  logic [9:0]        cnt_q;
  logic [9:0]        div_q;
  logic              txd_q;
  logic              busy_q;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic [IDX_W-1:0]  win_d;
  logic              win_vld_d;
  logic [IDX_W-1:0]  ptr_d;
  logic              bit_done;

  // Search downward from the farthest offset so the nearest set req at/after ptr wins.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    win_d     = '0;
    win_vld_d = 1'b0;
    idx       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        win_d     = IDX_W'(idx);
        win_vld_d = 1'b1;
      end
    end
  end

  assign ptr_d    = (win_d == IDX_W'(NREQ - 1)) ? '0 : win_d + 1'b1;
  assign bit_done = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
      gnt_q <= '0;
      if (state_q != S_IDLE) cnt_q <= bit_done ? div_q : cnt_q - 1'b1;
      case (state_q)
        S_IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          if (win_vld_d) begin
            gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << win_d;
            shift_q  <= data[{win_d, 3'b000} +: 8];
            owner_q  <= win_d;
            div_q    <= baudselect;
            cnt_q    <= baudselect;
            txd_q    <= 1'b0;
            busy_q   <= 1'b1;
            ptr_q    <= ptr_d;
            state_q  <= S_START;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^data[{win_d, 3'b000} +: 8];
`endif
          end
        end
        S_START: if (bit_done) begin
          txd_q     <= shift_q[0];
          bit_idx_q <= '0;
          state_q   <= S_DATA;
        end
        S_DATA: if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_q   <= parity_q;
            state_q <= S_PARITY;
`else
            txd_q   <= 1'b1;
            state_q <= S_STOP;
`endif
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
            shift_q   <= shift_q >> 1;
            txd_q     <= shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (bit_done) begin
          txd_q   <= 1'b1;
          state_q <= S_STOP;
        end
`endif
        S_STOP: if (bit_done) begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign txd   = txd_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed testbench for uart_tx_scheduler (NREQ=4); parity checks follow UART_TX_PARITY_EN.
module tb_uart_tx_scheduler;

`ifdef UART_TX_PARITY_EN
  localparam int NLEV = 11;
`else
  localparam int NLEV = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  baudselect;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        txd;
  logic        busy;
  logic [1:0]  owner;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_scheduler #(.NREQ(4), .IDX_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baudselect (baudselect),
    .req        (req),
    .data       (data),
    .gnt        (gnt),
    .txd        (txd),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for frame slot lvl: start, 8 data bits LSB first, [parity], stop.
  function automatic logic exp_level(input logic [7:0] b, input int lvl);
    if (lvl == 0) return 1'b0;
    if (lvl <= 8) return b[lvl-1];
`ifdef UART_TX_PARITY_EN
    if (lvl == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wait_gnt(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (gnt !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; data = '0; baudselect = '0;
    tick(); tick();
    vectors += 4;
    if (txd !== 1'b1)     begin miscompares++; $display("FAIL reset_txd: got %b expected 1", txd); end
    if (busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (gnt !== 4'b0000)  begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    if (owner !== 2'd0)   begin miscompares++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    reset_n = 1'b1;
    tick(); tick();
    vectors += 2;
    if (txd !== 1'b1)  begin miscompares++; $display("FAIL idle_txd: got %b expected 1", txd); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_contention();
    bit ok;
    logic [3:0] eg;
    logic e;
    baudselect = 10'd0;
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req  = 4'b1111;
    wait_gnt(4, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL contention_first_gnt: got none expected 0001"); end
    for (int f = 0; f < 4; f++) begin
      if (f > 0) tick();
      eg = 4'b0001 << f;
      vectors += 2;
      if (gnt !== eg)          begin miscompares++; $display("FAIL contention_gnt f%0d: got %b expected %b", f, gnt, eg); end
      if (owner !== 2'(f))     begin miscompares++; $display("FAIL contention_owner f%0d: got %0d expected %0d", f, owner, f); end
      if (f == 3) req = 4'b0000;
      for (int k = 0; k < NLEV; k++) begin
        e = exp_level(data[8*f +: 8], k);
        vectors += 2;
        if (txd !== e)     begin miscompares++; $display("FAIL contention_txd f%0d k%0d: got %b expected %b", f, k, txd, e); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL contention_busy f%0d k%0d: got %b expected 1", f, k, busy); end
        tick();
      end
      vectors += 2;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL contention_gap_busy f%0d: got %b expected 0", f, busy); end
      if (txd !== 1'b1)  begin miscompares++; $display("FAIL contention_gap_txd f%0d: got %b expected 1", f, txd); end
    end
  endtask

  task automatic test_fairness_wrap();
    bit ok;
    logic e;
    data = {8'h96, 8'h00, 8'h00, 8'h69};
    req  = 4'b1001;
    wait_gnt(4, ok);
    vectors += 3;
    if (!ok)             begin miscompares++; $display("FAIL wrap_first_gnt: got none expected 0001"); end
    if (gnt !== 4'b0001) begin miscompares++; $display("FAIL wrap_gnt0: got %b expected 0001", gnt); end
    if (owner !== 2'd0)  begin miscompares++; $display("FAIL wrap_owner0: got %0d expected 0", owner); end
    req = 4'b1000;
    for (int k = 0; k < NLEV; k++) begin
      e = exp_level(8'h69, k);
      vectors++;
      if (txd !== e) begin miscompares++; $display("FAIL wrap_txd0 k%0d: got %b expected %b", k, txd, e); end
      tick();
    end
    tick();
    vectors += 2;
    if (gnt !== 4'b1000) begin miscompares++; $display("FAIL wrap_gnt3: got %b expected 1000", gnt); end
    if (owner !== 2'd3)  begin miscompares++; $display("FAIL wrap_owner3: got %0d expected 3", owner); end
    req = 4'b0000;
    for (int k = 0; k < NLEV; k++) begin
      e = exp_level(8'h96, k);
      vectors++;
      if (txd !== e) begin miscompares++; $display("FAIL wrap_txd3 k%0d: got %b expected %b", k, txd, e); end
      tick();
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL wrap_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    bit ok;
    logic e;
    baudselect = 10'd3;
    data = {8'h00, 8'hA5, 8'h00, 8'h00};
    req  = 4'b0100;
    wait_gnt(4, ok);
    vectors += 4;
    if (!ok)             begin miscompares++; $display("FAIL single_gnt_seen: got none expected 0100"); end
    if (gnt !== 4'b0100) begin miscompares++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
    if (owner !== 2'd2)  begin miscompares++; $display("FAIL single_owner: got %0d expected 2", owner); end
    if (busy !== 1'b1)   begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
    req = 4'b0000;
    for (int k = 0; k < NLEV*4; k++) begin
      e = exp_level(8'hA5, k / 4);
      vectors += 2;
      if (txd !== e)     begin miscompares++; $display("FAIL single_txd k%0d: got %b expected %b", k, txd, e); end
      if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy k%0d: got %b expected 1", k, busy); end
      if (k == 1) begin
        vectors++;
        if (gnt !== 4'b0000) begin miscompares++; $display("FAIL single_gnt_pulse: got %b expected 0000", gnt); end
      end
      tick();
    end
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL single_end_busy: got %b expected 0", busy); end
    if (txd !== 1'b1)  begin miscompares++; $display("FAIL single_end_txd: got %b expected 1", txd); end
  endtask

  task automatic test_baud_change();
    bit ok;
    logic e;
    baudselect = 10'd2;
    data = {8'h00, 8'h00, 8'h5A, 8'h00};
    req  = 4'b0010;
    wait_gnt(4, ok);
    vectors += 2;
    if (!ok)             begin miscompares++; $display("FAIL baud_gnt_seen: got none expected 0010"); end
    if (gnt !== 4'b0010) begin miscompares++; $display("FAIL baud_gnt1: got %b expected 0010", gnt); end
    data[15:8] = 8'hC3;
    for (int k = 0; k < NLEV*3; k++) begin
      if (k == 8) baudselect = 10'd7;
      e = exp_level(8'h5A, k / 3);
      vectors++;
      if (txd !== e) begin miscompares++; $display("FAIL baud_txd3 k%0d: got %b expected %b", k, txd, e); end
      tick();
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL baud_mid_busy: got %b expected 0", busy); end
    tick();
    vectors++;
    if (gnt !== 4'b0010) begin miscompares++; $display("FAIL baud_gnt2: got %b expected 0010", gnt); end
    req = 4'b0000;
    for (int k = 0; k < NLEV*8; k++) begin
      e = exp_level(8'hC3, k / 8);
      vectors++;
      if (txd !== e) begin miscompares++; $display("FAIL baud_txd8 k%0d: got %b expected %b", k, txd, e); end
      tick();
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL baud_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    logic e;
    baudselect = 10'd1;
    data = {8'h00, 8'h00, 8'h00, 8'h3C};
    req  = 4'b0001;
    wait_gnt(4, ok);
    vectors++;
    if (!ok || gnt !== 4'b0001) begin miscompares++; $display("FAIL rst_pre_gnt: got %b expected 0001", gnt); end
    req = 4'b0000;
    for (int k = 0; k < 10; k++) tick();
    vectors += 2;
    if (txd !== 1'b1)  begin miscompares++; $display("FAIL rst_bit4_txd: got %b expected 1", txd); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_bit4_busy: got %b expected 1", busy); end
    reset_n = 1'b0;
    #1;
    vectors += 4;
    if (txd !== 1'b1)    begin miscompares++; $display("FAIL rst_async_txd: got %b expected 1", txd); end
    if (busy !== 1'b0)   begin miscompares++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rst_async_gnt: got %b expected 0000", gnt); end
    if (owner !== 2'd0)  begin miscompares++; $display("FAIL rst_async_owner: got %0d expected 0", owner); end
    req = 4'b0001;
    tick(); tick();
    reset_n = 1'b1;
    wait_gnt(3, ok);
    vectors += 2;
    if (!ok || gnt !== 4'b0001) begin miscompares++; $display("FAIL rst_post_gnt: got %b expected 0001", gnt); end
    if (owner !== 2'd0)         begin miscompares++; $display("FAIL rst_post_owner: got %0d expected 0", owner); end
    req = 4'b0000;
    for (int k = 0; k < NLEV*2; k++) begin
      e = exp_level(8'h3C, k / 2);
      vectors++;
      if (txd !== e) begin miscompares++; $display("FAIL rst_post_txd k%0d: got %b expected %b", k, txd, e); end
      tick();
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_post_busy: got %b expected 0", busy); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    logic e;
    baudselect = 10'd1;
    data = {8'h00, 8'h00, 8'h00, 8'h07};
    req  = 4'b0001;
    wait_gnt(4, ok);
    vectors++;
    if (!ok || gnt !== 4'b0001) begin miscompares++; $display("FAIL parity_gnt: got %b expected 0001", gnt); end
    req = 4'b0000;
    for (int k = 0; k < 22; k++) begin
      e = (k / 2 == 9) ? 1'b1 : exp_level(8'h07, k / 2);
      vectors += 2;
      if (txd !== e)     begin miscompares++; $display("FAIL parity_txd k%0d: got %b expected %b", k, txd, e); end
      if (busy !== 1'b1) begin miscompares++; $display("FAIL parity_busy k%0d: got %b expected 1", k, busy); end
      tick();
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL parity_end_busy: got %b expected 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_fairness_wrap();
    test_single();
    test_baud_change();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
